// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and grant encoding for the register-file write-back arbiter.
package regfile_wb_arbiter_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned REG_ZERO   = 0;
  localparam int unsigned REG_RA     = 31;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_LINK = 2'd1,
    GNT_ALU  = 2'd2,
    GNT_MEM  = 2'd3
  } grant_e;

endpackage

// File: rtl/regfile_wb_arbiter_fifo.sv
// Small synchronous FIFO holding {addr,data} write-back entries for one source.
module wb_fifo #(
  parameter int unsigned W     = 37,
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q;
  logic [PW-1:0] rd_q;
  logic [PW:0]   cnt_q;
  logic          push_ok;
  logic          pop_ok;

  assign full_o  = (cnt_q == (PW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_q];

  // Storage array; contents are don't-care while empty, so no reset.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_q] <= din_i;
  end

  // Pointers and occupancy; simultaneous push and pop leave the count unchanged.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + 1'b1;
      if (pop_ok)  rd_q <= rd_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port owner: buffers ALU/load results, takes JAL link writes,
// arbitrates one write per cycle and tracks outstanding destinations.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              link_valid,
  input  logic [DATA_W-1:0] link_data,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_addr,
  output logic              WE3,
  output logic [ADDR_W-1:0] A3,
  output logic [DATA_W-1:0] WD3,
  output logic [31:0]       busy_mask
);

  localparam int unsigned EW = ADDR_W + DATA_W;

  logic [EW-1:0]     alu_head, mem_head;
  logic              alu_full, alu_empty, mem_full, mem_empty;
  logic              alu_pop, mem_pop;
  logic              link_pend_q;
  logic [DATA_W-1:0] link_data_q;
  grant_e            gnt, last_grant_q;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic              we_d;
  logic [31:0]       busy_d;

  assign alu_ready = !alu_full && !RST;
  assign mem_ready = !mem_full && !RST;

  wb_fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_alu_fifo (
    .clk_i  (CLK),
    .rst_i  (RST),
    .push_i (alu_valid && alu_ready),
    .din_i  ({alu_addr, alu_data}),
    .pop_i  (alu_pop),
    .head_o (alu_head),
    .full_o (alu_full),
    .empty_o(alu_empty)
  );

  wb_fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_mem_fifo (
    .clk_i  (CLK),
    .rst_i  (RST),
    .push_i (mem_valid && mem_ready),
    .din_i  ({mem_addr, mem_data}),
    .pop_i  (mem_pop),
    .head_o (mem_head),
    .full_o (mem_full),
    .empty_o(mem_empty)
  );

  // Grant select: pending link first, otherwise round-robin over non-empty heads.
  always_comb begin
    gnt      = GNT_NONE;
    sel_addr = '0;
    sel_data = '0;
    if (link_pend_q) begin
      gnt = GNT_LINK;
    end else if (!alu_empty && !mem_empty) begin
      gnt = (last_grant_q == GNT_ALU) ? GNT_MEM : GNT_ALU;
    end else if (!alu_empty) begin
      gnt = GNT_ALU;
    end else if (!mem_empty) begin
      gnt = GNT_MEM;
    end
    case (gnt)
      GNT_LINK: begin
        sel_addr = ADDR_W'(REG_RA);
        sel_data = link_data_q;
      end
      GNT_ALU:  {sel_addr, sel_data} = alu_head;
      GNT_MEM:  {sel_addr, sel_data} = mem_head;
      default: ;
    endcase
  end

  assign alu_pop = (gnt == GNT_ALU);
  assign mem_pop = (gnt == GNT_MEM);
  assign we_d    = (gnt != GNT_NONE) && (sel_addr != ADDR_W'(REG_ZERO));

  // Scoreboard next state: clear the committed destination, then let a new issue re-set it.
  always_comb begin
    busy_d = busy_mask;
    if (we_d) busy_d[sel_addr] = 1'b0;
    if (issue_valid && (issue_addr != ADDR_W'(REG_ZERO))) busy_d[issue_addr] = 1'b1;
  end

  // Link register: a fresh capture overrides the drain of the previous value.
  always_ff @(posedge CLK) begin
    if (RST) begin
      link_pend_q <= 1'b0;
      link_data_q <= '0;
    end else if (link_valid) begin
      link_pend_q <= 1'b1;
      link_data_q <= link_data;
    end else if (gnt == GNT_LINK) begin
      link_pend_q <= 1'b0;
    end
  end

  // Round-robin history; link grants leave it alone so ALU/MEM order resumes unchanged.
  always_ff @(posedge CLK) begin
    if (RST) begin
      last_grant_q <= GNT_MEM;
    end else if ((gnt == GNT_ALU) || (gnt == GNT_MEM)) begin
      last_grant_q <= gnt;
    end
  end

  // Registered write port; address/data hold when no write is issued.
  always_ff @(posedge CLK) begin
    if (RST) begin
      WE3 <= 1'b0;
      A3  <= '0;
      WD3 <= '0;
    end else begin
      WE3 <= we_d;
      if (we_d) begin
        A3  <= sel_addr;
        WD3 <= sel_data;
      end
    end
  end

  // Pending-write scoreboard register.
  always_ff @(posedge CLK) begin
    if (RST) busy_mask <= '0;
    else     busy_mask <= busy_d;
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter.
module tb_regfile_wb_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        alu_valid, mem_valid, link_valid, issue_valid;
  logic        alu_ready, mem_ready;
  logic [4:0]  alu_addr, mem_addr, issue_addr;
  logic [31:0] alu_data, mem_data, link_data;
  logic        WE3;
  logic [4:0]  A3;
  logic [31:0] WD3;
  logic [31:0] busy_mask;

  int n_checks = 0;
  int n_errors = 0;

  regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .FIFO_DEPTH(2)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .alu_valid  (alu_valid),
    .alu_ready  (alu_ready),
    .alu_addr   (alu_addr),
    .alu_data   (alu_data),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .link_valid (link_valid),
    .link_data  (link_data),
    .issue_valid(issue_valid),
    .issue_addr (issue_addr),
    .WE3        (WE3),
    .A3         (A3),
    .WD3        (WD3),
    .busy_mask  (busy_mask)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then settle 1 time unit past it.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Expected k-th write of the alternating ALU/MEM stream.
  task automatic check_stream(input int k);
    check_eq($sformatf("stream%0d_we", k), {31'd0, WE3}, 32'd1);
    check_eq($sformatf("stream%0d_a3", k), {27'd0, A3}, (k % 2 == 0) ? 32'd3 : 32'd4);
    check_eq($sformatf("stream%0d_wd", k), WD3,
             (k % 2 == 0) ? 32'h100 + 32'(k / 2) : 32'h200 + 32'(k / 2));
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    tick();
  endtask

  initial begin
    int na, nm;
    logic ar, mr;
    RST = 1'b1;
    alu_valid = 0; mem_valid = 0; link_valid = 0; issue_valid = 0;
    alu_addr = '0; mem_addr = '0; issue_addr = '0;
    alu_data = '0; mem_data = '0; link_data = '0;

    // Reset state
    tick();
    tick();
    check_eq("rst_we", {31'd0, WE3}, 32'd0);
    check_eq("rst_a3", {27'd0, A3}, 32'd0);
    check_eq("rst_wd", WD3, 32'd0);
    check_eq("rst_busy", busy_mask, 32'd0);
    check_eq("rst_alu_rdy", {31'd0, alu_ready}, 32'd0);
    check_eq("rst_mem_rdy", {31'd0, mem_ready}, 32'd0);
    RST = 1'b0;
    tick();
    check_eq("post_rst_alu_rdy", {31'd0, alu_ready}, 32'd1);
    check_eq("post_rst_mem_rdy", {31'd0, mem_ready}, 32'd1);

    // Single ALU write with prior issue of its destination
    issue_valid = 1; issue_addr = 5;
    tick();
    issue_valid = 0;
    check_eq("issue5_busy", busy_mask, 32'h0000_0020);
    alu_valid = 1; alu_addr = 5; alu_data = 32'hDEADBEEF;
    tick();
    alu_valid = 0;
    check_eq("single_e1_we", {31'd0, WE3}, 32'd0);
    tick();
    check_eq("single_e2_we", {31'd0, WE3}, 32'd1);
    check_eq("single_e2_a3", {27'd0, A3}, 32'd5);
    check_eq("single_e2_wd", WD3, 32'hDEADBEEF);
    check_eq("single_e2_busy", busy_mask, 32'd0);
    tick();
    check_eq("single_e3_we", {31'd0, WE3}, 32'd0);
    check_eq("single_e3_a3_hold", {27'd0, A3}, 32'd5);

    // Back-to-back link captures; second value survives the drain edge
    issue_valid = 1; issue_addr = 31;
    tick();
    issue_valid = 0;
    check_eq("issue31_busy", busy_mask, 32'h8000_0000);
    link_valid = 1; link_data = 32'hAAAA0001;
    tick();
    link_data = 32'hBBBB0002;
    tick();
    link_valid = 0;
    check_eq("link1_a3", {27'd0, A3}, 32'd31);
    check_eq("link1_wd", WD3, 32'hAAAA0001);
    tick();
    check_eq("link2_we", {31'd0, WE3}, 32'd1);
    check_eq("link2_wd", WD3, 32'hBBBB0002);
    check_eq("link2_busy", busy_mask, 32'd0);
    tick();
    check_eq("link3_we", {31'd0, WE3}, 32'd0);

    // Alternating ALU/MEM stream from a fresh reset
    do_reset();
    na = 0; nm = 0;
    alu_valid = 1; mem_valid = 1; alu_addr = 3; mem_addr = 4;
    for (int s = 1; s <= 7; s++) begin
      alu_data = 32'h100 + 32'(na);
      mem_data = 32'h200 + 32'(nm);
      ar = alu_ready; mr = mem_ready;
      tick();
      if (ar) na++;
      if (mr) nm++;
      if (s == 1) check_eq("stream_first_we", {31'd0, WE3}, 32'd0);
      else        check_stream(s - 2);
      if (s == 2) check_eq("stream_mem_full_rdy", {31'd0, mem_ready}, 32'd0);
    end

    // Link jumps the queue while both FIFOs hold entries
    alu_valid = 0; mem_valid = 0;
    link_valid = 1; link_data = 32'h00400010;
    tick();
    link_valid = 0;
    check_stream(6);
    tick();
    check_eq("link_we", {31'd0, WE3}, 32'd1);
    check_eq("link_a3", {27'd0, A3}, 32'd31);
    check_eq("link_wd", WD3, 32'h00400010);
    tick();
    check_stream(7);
    tick();
    check_stream(8);
    tick();
    check_eq("drained_we", {31'd0, WE3}, 32'd0);

    // Writes to $0 pop silently; issue to $0 never marks busy
    issue_valid = 1; issue_addr = 9;
    tick();
    issue_addr = 0;
    alu_valid = 1; alu_addr = 0; alu_data = 32'h12345678;
    tick();
    issue_valid = 0; alu_valid = 0;
    check_eq("zero_issue_busy", busy_mask, 32'h0000_0200);
    tick();
    check_eq("zero_we", {31'd0, WE3}, 32'd0);
    check_eq("zero_a3_hold", {27'd0, A3}, 32'd3);
    check_eq("zero_wd_hold", WD3, 32'h104);
    check_eq("zero_busy", busy_mask, 32'h0000_0200);
    check_eq("zero_alu_rdy", {31'd0, alu_ready}, 32'd1);

    // Set wins over clear on the same register
    issue_valid = 1; issue_addr = 7;
    tick();
    issue_valid = 0;
    alu_valid = 1; alu_addr = 7; alu_data = 32'h77;
    tick();
    alu_valid = 0;
    issue_valid = 1; issue_addr = 7;
    tick();
    issue_valid = 0;
    check_eq("setwin_we", {31'd0, WE3}, 32'd1);
    check_eq("setwin_a3", {27'd0, A3}, 32'd7);
    check_eq("setwin_busy", busy_mask, 32'h0000_0280);
    alu_valid = 1; alu_data = 32'h78;
    tick();
    alu_valid = 0;
    tick();
    check_eq("clr7_wd", WD3, 32'h78);
    check_eq("clr7_busy", busy_mask, 32'h0000_0200);

    // Reset mid-operation discards buffered writes
    alu_valid = 1; mem_valid = 1; alu_addr = 10; mem_addr = 11;
    alu_data = 32'hA0; mem_data = 32'hB0;
    tick();
    tick();
    tick();
    alu_valid = 0; mem_valid = 0;
    RST = 1'b1;
    tick();
    check_eq("midrst_we", {31'd0, WE3}, 32'd0);
    check_eq("midrst_busy", busy_mask, 32'd0);
    check_eq("midrst_alu_rdy", {31'd0, alu_ready}, 32'd0);
    check_eq("midrst_mem_rdy", {31'd0, mem_ready}, 32'd0);
    RST = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq($sformatf("after_rst%0d_we", i), {31'd0, WE3}, 32'd0);
    end
    check_eq("after_rst_alu_rdy", {31'd0, alu_ready}, 32'd1);
    check_eq("after_rst_mem_rdy", {31'd0, mem_ready}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
